// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one operand bit per clock, LSB first.
// An accepted start captures a, b and cin. WIDTH edges later the block
// presents sum/cout and pulses done for one cycle.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             bit_s;
    logic             bit_c;
    logic             last_bit;

    // Full adder on the current LSBs plus the running carry.
    assign bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
    assign bit_c    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // State register and datapath flops, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples
        // pre-edge values; blocking would make results depend on statement order.
        if (rst) begin
            // NOTE: every register is cleared, including the shift registers,
            // so the block leaves reset with no stale operand or result state.
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state logic. start is only looked at in IDLE; DONE always returns to IDLE.
    always_comb begin
        // NOTE: the default assignment first means every path assigns
        // state_d, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ADD;
            ADD:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift one bit per ADD edge, load results on the last bit.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    res_d   = '0;
                    cnt_d   = '0;
                end
            end
            ADD: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {bit_s, res_q[WIDTH-1:1]};
                carry_d = bit_c;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    sum_d  = {bit_s, res_q[WIDTH-1:1]};
                    cout_d = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB at this point.
                    ovf_d  = carry_q ^ bit_c;
`endif
                end
            end
            default: ;
        endcase
    end

    // Outputs are decoded from the state and from the held result registers.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder with WIDTH=8.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] prev_sum  = '0;
    logic         prev_cout = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
        rst = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy); end
    endtask

    // One complete add. The operands are scrambled right after the accept
    // edge, and the result is checked W edges after that edge.
    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                           input logic [W-1:0] es, input logic ec, input logic eo, input string nm);
        start = 1'b1; a = ta; b = tb_v; cin = tcin;
        tick();
        start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tcin;
        for (int i = 0; i < W; i++) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy[%0d] got=%b want=1", nm, i, busy); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL %s early_done[%0d] got=%b want=0", nm, i, done); end
            total++; if (sum !== prev_sum) begin bad++; $display("FAIL %s sum_hold[%0d] got=%h want=%h", nm, i, sum, prev_sum); end
            tick();
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL %s done got=%b want=1", nm, done); end
        total++; if (sum !== es) begin bad++; $display("FAIL %s sum got=%h want=%h", nm, sum, es); end
        total++; if (cout !== ec) begin bad++; $display("FAIL %s cout got=%b want=%b", nm, cout, ec); end
`ifdef SERIAL_ADDER_OVF_EN
        total++; if (ovf !== eo) begin bad++; $display("FAIL %s ovf got=%b want=%b", nm, ovf, eo); end
`endif
        prev_sum  = es;
        prev_cout = ec;
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL %s done_pulse_len got=%b want=0", nm, done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_after got=%b want=0", nm, busy); end
        total++; if (sum !== es) begin bad++; $display("FAIL %s sum_after got=%h want=%h", nm, sum, es); end
        total++; if (cout !== ec) begin bad++; $display("FAIL %s cout_after got=%b want=%b", nm, cout, ec); end
    endtask

    task automatic test_vectors();
        run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "v_5a_3c");
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "v_ff_01");
        run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "v_80_80");
        run_add(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, "v_7f_00_c");
        run_add(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, "v_12_34_c");
    endtask

    // A start pulse with other operands during the 3rd ADD cycle must be ignored.
    task automatic test_ignore_start();
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
        tick();
        for (int i = 0; i < W; i++) begin
            if (i == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; end
            else        begin start = 1'b0; end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign busy[%0d] got=%b want=1", i, busy); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL ign early_done[%0d] got=%b want=0", i, done); end
            tick();
        end
        start = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ign done got=%b want=1", done); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign busy_done got=%b want=1", busy); end
        total++; if (sum !== 8'h33) begin bad++; $display("FAIL ign sum got=%h want=33", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL ign cout got=%b want=0", cout); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign busy_idle got=%b want=0", busy); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign not_queued got=%b want=0", busy); end
        prev_sum = 8'h33; prev_cout = 1'b0;
    endtask

    // Reset during the 4th ADD cycle aborts the add; the next add still works.
    task automatic test_reset_abort();
        start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort busy_pre got=%b want=1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort done got=%b want=0", done); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL abort sum got=%h want=00", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL abort cout got=%b want=0", cout); end
        for (int i = 0; i < W + 2; i++) begin
            tick();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL abort stray_done[%0d] got=%b want=0", i, done); end
        end
        prev_sum = 8'h00; prev_cout = 1'b0;
        run_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_abort");
    endtask

    // start held high: done every W+2 cycles, result stable between pulses.
    task automatic test_back_to_back();
        int last   = -1;
        int pulses = 0;
        start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
        for (int cyc = 0; cyc < 4 * (W + 2); cyc++) begin
            tick();
            if (done === 1'b1) begin
                if (last >= 0) begin
                    total++; if (cyc - last != W + 2) begin bad++; $display("FAIL b2b period got=%0d want=%0d", cyc - last, W + 2); end
                end
                last = cyc;
                pulses++;
            end
            if (pulses > 0) begin
                total++; if (sum !== 8'h10) begin bad++; $display("FAIL b2b sum[%0d] got=%h want=10", cyc, sum); end
                total++; if (cout !== 1'b0) begin bad++; $display("FAIL b2b cout[%0d] got=%b want=0", cyc, cout); end
            end
        end
        total++; if (pulses < 3) begin bad++; $display("FAIL b2b pulses got=%0d want>=3", pulses); end
        start = 1'b0;
        for (int i = 0; i < W + 3; i++) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b idle got=%b want=0", busy); end
        prev_sum = 8'h10; prev_cout = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
